// File: rtl/booth_divider_seq_if.sv
// Handshake and operand/result bundle for booth_divider_seq.
// The master side issues start/N/D; the slave side (the divider) returns busy/done/Q/R/dz/ovf.
interface booth_divider_seq_if #(
    parameter int TAM = 8
);
    logic                 start;
    logic [2*TAM-1:0]     N;
    logic [TAM-1:0]       D;
    logic                 busy;
    logic                 done;
    logic [2*TAM-1:0]     Q;
    logic [TAM-1:0]       R;
    logic                 dz;
    logic                 ovf;

    modport master (
        output start, N, D,
        input  busy, done, Q, R, dz, ovf
    );

    modport slave (
        input  start, N, D,
        output busy, done, Q, R, dz, ovf
    );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential signed restoring divider: 2*TAM-bit dividend by TAM-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_FASTPATH_EN lets divide-by-zero/overflow results bypass the iteration sequence.
module booth_divider_seq #(
    parameter int TAM = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth_divider_seq_if.slave bus
);
    localparam int CW = $clog2(2*TAM) + 1;
    localparam logic [2*TAM-1:0] MOST_NEG = {1'b1, {(2*TAM-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t state, next_state;

    logic [2*TAM-1:0] quo;
    logic [TAM:0]     rem;
    logic [TAM-1:0]   dmag;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r;
    logic             dz_pend, ovf_pend;
    logic [TAM-1:0]   n_low;

    logic             accept, finish;
    logic [2*TAM-1:0] n_mag;
    logic [TAM-1:0]   d_mag;
    logic             is_dz, is_ovf;
    logic [TAM:0]     shifted, trial;
    logic             fits;

    // Magnitudes are formed in unsigned width so the most-negative operands stay exact.
    always_comb begin
        n_mag   = bus.N[2*TAM-1] ? -bus.N : bus.N;
        d_mag   = bus.D[TAM-1]   ? -bus.D : bus.D;
        is_dz   = (bus.D == '0);
        is_ovf  = (bus.N == MOST_NEG) && (bus.D == '1);
        shifted = {rem[TAM-1:0], quo[2*TAM-1]};
        fits    = (shifted >= {1'b0, dmag});
        trial   = shifted - {1'b0, dmag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                    next_state = (is_dz || is_ovf) ? SIGN : CALC;
`else
                    next_state = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == CW'(2*TAM-1)) next_state = SIGN;
            end
            SIGN: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Special cases are classified at acceptance and override the iterated result when finishing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo      <= '0;
            rem      <= '0;
            dmag     <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            n_low    <= '0;
            bus.done <= 1'b0;
            bus.Q    <= '0;
            bus.R    <= '0;
            bus.dz   <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.done <= finish;
            if (accept) begin
                quo      <= n_mag;
                dmag     <= d_mag;
                rem      <= '0;
                cnt      <= '0;
                sign_q   <= bus.N[2*TAM-1] ^ bus.D[TAM-1];
                sign_r   <= bus.N[2*TAM-1];
                dz_pend  <= is_dz;
                ovf_pend <= is_ovf;
                n_low    <= bus.N[TAM-1:0];
            end else if (state == CALC) begin
                rem <= fits ? trial : shifted;
                quo <= {quo[2*TAM-2:0], fits};
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                if (dz_pend) begin
                    bus.Q   <= '1;
                    bus.R   <= n_low;
                    bus.dz  <= 1'b1;
                    bus.ovf <= 1'b0;
                end else if (ovf_pend) begin
                    bus.Q   <= MOST_NEG;
                    bus.R   <= '0;
                    bus.dz  <= 1'b0;
                    bus.ovf <= 1'b1;
                end else begin
                    bus.Q   <= sign_q ? -quo : quo;
                    bus.R   <= sign_r ? -rem[TAM-1:0] : rem[TAM-1:0];
                    bus.dz  <= 1'b0;
                    bus.ovf <= 1'b0;
                end
            end
        end
    end
endmodule
